// File: rtl/reset_sequencer.sv
// reset_sequencer: central reset controller downstream of the reset synchronizer.
// Holds all reset domains for HOLD_CYCLES after system reset or a software /
// watchdog request, then releases NUM_STAGES domains in order (bit 0 first)
// spaced STAGE_GAP cycles apart, and records the cause of the last reset.
//
// Optional feature (macro RESET_SEQ_ACK_EN): stage k>=1 additionally waits for
// StageAck[k-1], and Ready additionally waits for StageAck[NUM_STAGES-1].
//
// Ports:
//   Clock        in   system clock
//   Reset        in   asynchronous active-low reset (synchronized system reset)
//   SwResetReq   in   software reset request, level-sampled
//   WdtResetReq  in   watchdog reset request, level-sampled (wins over software)
//   StageAck     in   per-stage out-of-reset acknowledge (ack build only)
//   StageRst_n   out  staged active-low resets, registered
//   Ready        out  all stages released and sequencer in RUN, registered
//   ResetCause   out  00 external, 01 software, 10 watchdog, registered
module reset_sequencer #(
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  SwResetReq,
    input  logic                  WdtResetReq,
    input  logic [NUM_STAGES-1:0] StageAck,
    output logic [NUM_STAGES-1:0] StageRst_n,
    output logic                  Ready,
    output logic [1:0]            ResetCause
);

    localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

    localparam logic [1:0] CAUSE_EXT = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_ACKWAIT = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

`ifdef RESET_SEQ_ACK_EN
    localparam bit ACK_MODE = 1'b1;
`else
    localparam bit ACK_MODE = 1'b0;
`endif

    // After the last stage is released: straight to RUN, or wait for the final ack.
    localparam state_t DONE_ST = ACK_MODE ? ST_ACKWAIT : ST_RUN;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [NUM_STAGES-1:0]   stage_rst_n_nxt;
    logic                    ready_nxt;
    logic [1:0]              cause_nxt;

    logic                    gap_ack_c;
    logic                    last_ack_c;

    // Acknowledge qualifiers; constant-true when the ack feature is compiled out.
`ifdef RESET_SEQ_ACK_EN
    logic [IDX_W-1:0] prev_idx_c;
    assign prev_idx_c = idx - IDX_W'(1);
    assign gap_ack_c  = StageAck[prev_idx_c];
    assign last_ack_c = StageAck[NUM_STAGES-1];
`else
    logic unused_stage_ack;
    assign unused_stage_ack = ^StageAck;
    assign gap_ack_c  = 1'b1;
    assign last_ack_c = 1'b1;
`endif

    // State and registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            idx        <= '0;
            StageRst_n <= '0;
            Ready      <= 1'b0;
            ResetCause <= CAUSE_EXT;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            StageRst_n <= stage_rst_n_nxt;
            Ready      <= ready_nxt;
            ResetCause <= cause_nxt;
        end
    end

    // Next-state and next-output logic; requests override every state.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        idx_nxt         = idx;
        stage_rst_n_nxt = StageRst_n;
        ready_nxt       = Ready;
        cause_nxt       = ResetCause;

        if (WdtResetReq || SwResetReq) begin
            state_nxt       = ST_HOLD;
            cnt_nxt         = '0;
            idx_nxt         = '0;
            stage_rst_n_nxt = '0;
            ready_nxt       = 1'b0;
            cause_nxt       = WdtResetReq ? CAUSE_WDT : CAUSE_SW;
        end else begin
            unique case (state)
                ST_HOLD: begin
                    stage_rst_n_nxt = '0;
                    if (cnt == HOLD_LAST) begin
                        cnt_nxt            = '0;
                        stage_rst_n_nxt[0] = 1'b1;
                        if (NUM_STAGES == 1) begin
                            state_nxt = DONE_ST;
                            ready_nxt = !ACK_MODE;
                        end else begin
                            state_nxt = ST_RELEASE;
                            idx_nxt   = IDX_W'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end

                ST_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        // Gap expired: release only with the previous stage's ack,
                        // otherwise park the counter at its terminal value.
                        if (gap_ack_c) begin
                            stage_rst_n_nxt[idx] = 1'b1;
                            cnt_nxt              = '0;
                            if (idx == LAST_IDX) begin
                                state_nxt = DONE_ST;
                                ready_nxt = !ACK_MODE;
                            end else begin
                                idx_nxt = idx + IDX_W'(1);
                            end
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end

                ST_ACKWAIT: begin
                    if (last_ack_c) begin
                        state_nxt = ST_RUN;
                        ready_nxt = 1'b1;
                    end
                end

                ST_RUN: begin
                    stage_rst_n_nxt = '1;
                    ready_nxt       = 1'b1;
                end

                default: begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer (default parameters). Stimulus pushes the
// expected output changes (with the clock edge they must appear on); the monitor
// pops one entry whenever the DUT outputs change and flags missing changes.
module tb_reset_sequencer;

    logic       Clock;
    logic       Reset;
    logic       SwResetReq;
    logic       WdtResetReq;
    logic [2:0] StageAck;
    logic [2:0] StageRst_n;
    logic       Ready;
    logic [1:0] ResetCause;

    reset_sequencer #(
        .NUM_STAGES (3),
        .HOLD_CYCLES(16),
        .STAGE_GAP  (4),
        .CNT_W      (8)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .SwResetReq (SwResetReq),
        .WdtResetReq(WdtResetReq),
        .StageAck   (StageAck),
        .StageRst_n (StageRst_n),
        .Ready      (Ready),
        .ResetCause (ResetCause)
    );

    typedef struct {
        int         cyc;
        logic [2:0] stg;
        logic       rdy;
        logic [1:0] cause;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_vec;
    int   n_err;
    logic [5:0] prev;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Edge counter: value seen at a negedge is the number of the preceding posedge.
    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic push(input int c, input logic [2:0] s, input logic r, input logic [1:0] ca);
        exp_t e;
        e.cyc = c; e.stg = s; e.rdy = r; e.cause = ca;
        q.push_back(e);
    endtask

    // Full sequence where base is the first edge after the request/reset ends.
    task automatic push_seq(input int base, input logic [1:0] ca);
        push(base + 15, 3'b001, 1'b0, ca);
        push(base + 19, 3'b011, 1'b0, ca);
        push(base + 23, 3'b111, 1'b1, ca);
    endtask

    task automatic check_now(input string name, input logic [2:0] s, input logic r, input logic [1:0] ca);
        n_vec++;
        if (StageRst_n !== s || Ready !== r || ResetCause !== ca) begin
            n_err++;
            $display("FAIL %s: got stg=%b rdy=%b cause=%b, want stg=%b rdy=%b cause=%b",
                     name, StageRst_n, Ready, ResetCause, s, r, ca);
        end
    endtask

    // Monitor: every output change must match the head of the queue at its edge.
    always @(negedge Clock) begin
        exp_t e;
        if (Reset) begin
            if ({StageRst_n, Ready, ResetCause} !== prev) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_change: cyc=%0d got stg=%b rdy=%b cause=%b, want no change",
                             cyc, StageRst_n, Ready, ResetCause);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || StageRst_n !== e.stg || Ready !== e.rdy || ResetCause !== e.cause) begin
                        n_err++;
                        $display("FAIL change: cyc=%0d got stg=%b rdy=%b cause=%b, want cyc=%0d stg=%b rdy=%b cause=%b",
                                 cyc, StageRst_n, Ready, ResetCause, e.cyc, e.stg, e.rdy, e.cause);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missing_change: cyc=%0d got stg=%b rdy=%b cause=%b, want cyc=%0d stg=%b rdy=%b cause=%b",
                         cyc, StageRst_n, Ready, ResetCause, e.cyc, e.stg, e.rdy, e.cause);
            end
        end
        prev = {StageRst_n, Ready, ResetCause};
    end

    initial begin
        int e;
        int base;
        n_vec = 0;
        n_err = 0;
        prev  = 6'b000000;
        Reset       = 1'b0;
        SwResetReq  = 1'b0;
        WdtResetReq = 1'b0;
`ifdef RESET_SEQ_ACK_EN
        StageAck    = 3'b111;
`else
        StageAck    = 3'b000;   // ignored in the default build
`endif

        repeat (3) @(negedge Clock);
        check_now("reset_state", 3'b000, 1'b0, 2'b00);

        // Power-on sequence.
        Reset = 1'b1;
        push_seq(cyc + 1, 2'b00);
        repeat (30) @(negedge Clock);

        // Software reset pulse in RUN.
        e = cyc + 1;
        push(e, 3'b000, 1'b0, 2'b01);
        push_seq(e + 1, 2'b01);
        SwResetReq = 1'b1;
        @(negedge Clock);
        SwResetReq = 1'b0;
        repeat (30) @(negedge Clock);

        // Simultaneous requests: watchdog wins.
        e = cyc + 1;
        push(e, 3'b000, 1'b0, 2'b10);
        push_seq(e + 1, 2'b10);
        SwResetReq  = 1'b1;
        WdtResetReq = 1'b1;
        @(negedge Clock);
        SwResetReq  = 1'b0;
        WdtResetReq = 1'b0;
        repeat (30) @(negedge Clock);

        // Software restart, then watchdog one cycle after stage 1 releases.
        e = cyc + 1;
        push(e, 3'b000, 1'b0, 2'b01);
        push(e + 16, 3'b001, 1'b0, 2'b01);
        push(e + 20, 3'b011, 1'b0, 2'b01);
        SwResetReq = 1'b1;
        @(negedge Clock);
        SwResetReq = 1'b0;
        repeat (20) @(negedge Clock);
        e = cyc + 1;
        push(e, 3'b000, 1'b0, 2'b10);
        push_seq(e + 1, 2'b10);
        WdtResetReq = 1'b1;
        @(negedge Clock);
        WdtResetReq = 1'b0;
        repeat (30) @(negedge Clock);

        // Async reset during RELEASE: clears without a clock edge.
        e = cyc + 1;
        push(e, 3'b000, 1'b0, 2'b01);
        push(e + 16, 3'b001, 1'b0, 2'b01);
        SwResetReq = 1'b1;
        @(negedge Clock);
        SwResetReq = 1'b0;
        repeat (18) @(negedge Clock);
        #2 Reset = 1'b0;
        #1 check_now("async_reset", 3'b000, 1'b0, 2'b00);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        push_seq(cyc + 1, 2'b00);
        repeat (30) @(negedge Clock);

`ifdef RESET_SEQ_ACK_EN
        // Stage 1 waits for StageAck[0]; Ready waits for StageAck[2].
        StageAck = 3'b000;
        e = cyc + 1;
        base = e + 1;
        push(e, 3'b000, 1'b0, 2'b01);
        push(base + 15, 3'b001, 1'b0, 2'b01);
        push(base + 30, 3'b011, 1'b0, 2'b01);
        push(base + 34, 3'b111, 1'b0, 2'b01);
        push(base + 40, 3'b111, 1'b1, 2'b01);
        SwResetReq = 1'b1;
        @(negedge Clock);
        SwResetReq = 1'b0;
        repeat (30) @(negedge Clock);
        StageAck = 3'b011;
        repeat (10) @(negedge Clock);
        StageAck = 3'b111;
        repeat (5) @(negedge Clock);
`else
        base = 0;
`endif

        // Drain the scoreboard with a bound.
        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge Clock);
        if (q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending changes, want 0 (base %0d)", q.size(), base);
        end
        check_now("final_run", 3'b111, 1'b1, 2'b00 | ((base != 0) ? 2'b01 : 2'b00));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Central reset controller downstream of the reset synchronizer.
- Holds all subsystems in reset for a fixed period after the synchronized system reset releases, or after a software or watchdog reset request.
- Then releases NUM_STAGES reset domains in order, with a fixed gap between stages, and records the cause of the last reset.
- Lets the memory, core and peripherals come out of reset in a controlled order.

Parameters:
- NUM_STAGES, 3: number of staged reset outputs; valid range 1..8.
- HOLD_CYCLES, 16: cycles all stages are held in reset before the first release; must be ≥1.
- STAGE_GAP, 4: cycles between consecutive stage releases; must be ≥1.
- CNT_W, 8: counter width; must hold max(HOLD_CYCLES, STAGE_GAP).

Ports:
- Clock  input  1  system clock.
- Reset  input  1  asynchronous, active-low reset (driven by the synchronized system reset).
- SwResetReq  input  1  software reset request, level-sampled each cycle, synchronous to Clock.
- WdtResetReq  input  1  watchdog reset request, level-sampled each cycle, synchronous to Clock.
- StageAck  input  NUM_STAGES  per-stage "out of reset" acknowledge; used only when RESET_SEQ_ACK_EN is defined.
- StageRst_n  output  NUM_STAGES  active-low resets; bit 0 releases first.
- Ready  output  1  high when every stage is released and the sequencer is in RUN.
- ResetCause  output  2  cause of last reset: 00 power-on/external, 01 software, 10 watchdog, 11 unused.

Behaviour:
- Reset is decided as asynchronous, active-low; the clock is Clock. All state elements use an asynchronous clear on Reset low.
- While Reset is low:
  - state = HOLD, counter = 0, stage index = 0.
  - StageRst_n = all 0, Ready = 0, ResetCause = 00.
- All outputs are registered; no combinational path from inputs to outputs.
- States:
  - HOLD: all stages in reset; counter increments each cycle. When counter = HOLD_CYCLES-1, the next edge sets StageRst_n[0] = 1 and loads the counter with 0.
    - If NUM_STAGES = 1, that same edge goes to RUN and sets Ready = 1.
    - Otherwise it goes to RELEASE with stage index = 1.
  - RELEASE: counter increments each cycle. When counter = STAGE_GAP-1, the next edge sets StageRst_n[index] = 1, clears the counter and increments the index.
    - The edge that releases the last stage enters RUN and sets Ready = 1 simultaneously.
  - RUN: StageRst_n all 1, Ready = 1; idle until a request arrives.
- Release timing: let T0 be the first rising edge with Reset high.
  - Stage k rises at edge T0 + HOLD_CYCLES - 1 + k*STAGE_GAP.
  - Ready rises at the same edge as stage NUM_STAGES-1.
  - With defaults: stage 0 at T0+15, stage 1 at T0+19, stage 2 at T0+23; Ready at T0+23.
- Requests (any state): if SwResetReq or WdtResetReq is high at an edge, that edge:
  - sets StageRst_n = all 0 and Ready = 0;
  - enters HOLD with counter = 0 and index = 0;
  - updates ResetCause.
- A request held high keeps the sequencer in HOLD with the counter at 0. Release begins HOLD_CYCLES after the request drops.
- Simultaneous requests: WdtResetReq has priority; ResetCause = 10.
- A request during HOLD or RELEASE restarts the full sequence. Stages that were already released go low again.
- ResetCause is cleared only by Reset. Requests overwrite it; it is not cleared by the internal sequence.
- Counter never wraps: it stops at its terminal value because the state changes on that edge.

Optional Feature:
- Macro: RESET_SEQ_ACK_EN.
- Defined:
  - In RELEASE, stage k (k≥1) is released only when the gap has expired AND StageAck[k-1] = 1 in the same cycle.
  - If the gap has expired without the ack, the counter holds at STAGE_GAP-1 and the sequencer waits indefinitely.
  - Ready additionally requires StageAck[NUM_STAGES-1] = 1: it rises on the first edge after the last release at which that ack is high.
  - Requests still abort a wait immediately.
- Undefined: StageAck is ignored (input left unconnected-safe); timing is exactly as in Behaviour.

Test Plan:
- Power-on, defaults: release Reset, hold requests low -> StageRst_n goes 000→001 at T0+15, 011 at T0+19, 111 at T0+23; Ready=1 at T0+23; ResetCause=00.
- Software reset in RUN: pulse SwResetReq for 1 cycle at edge E -> StageRst_n=000 and Ready=0 after E; stage 0 at E+16, stages 1 and 2 at E+20 and E+24; ResetCause=01.
- Simultaneous requests: assert SwResetReq and WdtResetReq on the same edge -> ResetCause=10; full re-sequence.
- Request mid-release: assert WdtResetReq one cycle after stage 1 releases -> StageRst_n returns to 000 immediately; sequence restarts from HOLD; ResetCause=10.
- Async reset mid-sequence: drive Reset low during RELEASE -> all outputs clear without a clock edge; ResetCause=00; normal power-on timing after release.
- RESET_SEQ_ACK_EN defined: hold StageAck[0]=0 until T0+30 -> stage 1 releases on the edge at which StageAck[0]=1 is first sampled, not at T0+19; Ready waits for StageAck[2]=1.
